// File: rtl/sram_arb_ctrl.sv
// Round-robin arbiter and sequencer for a single-port 32-bit SRAM macro.
// Zero-fills the array after reset, then serves read and byte-masked write requests from two clients.
module sram_arb_ctrl #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [31:0]   req_wdata0,
  input  logic [31:0]   req_wdata1,
  input  logic [3:0]    req_be0,
  input  logic [3:0]    req_be1,
  output logic [1:0]    req_ready,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [31:0]   rsp_rdata,
  output logic          init_done,
  output logic [AW-1:0] a,
  output logic          cen,
  output logic [31:0]   d,
  output logic          gwen,
  output logic [31:0]   wen,
  input  logic [31:0]   q
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS} state_t;

  localparam logic [AW:0] INIT_LAST = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   init_cnt_q, init_cnt_d;
  logic          rr_q, rr_d;
  logic          init_done_q, init_done_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [1:0]    grant;
  logic          sel;
  logic          serving;
  logic [3:0]    be_sel;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_d        = rr_q;
    init_done_d = init_done_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    grant       = 2'b00;
    sel         = 1'b0;
    be_sel      = 4'h0;
    cen         = 1'b0;
    gwen        = 1'b0;
    wen         = '0;
    a           = '0;
    d           = '0;
    // A pending synchronous reset silences the macro and the handshake immediately.
    serving     = init_done_q && !rst;

    unique case (state_q)
      S_INIT: begin
        if (!rst) begin
          cen  = 1'b1;
          gwen = 1'b1;
          wen  = '1;
          a    = init_cnt_q[AW-1:0];
        end
        init_cnt_d = init_cnt_q + CNT_ONE;
        if (init_cnt_q == INIT_LAST) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (serving && (req_valid != 2'b00)) begin
          // The pointer only moves when both clients compete.
          if (req_valid == 2'b11) begin
            sel  = rr_q;
            rr_d = ~rr_q;
          end else begin
            sel = req_valid[1];
          end
          grant[sel] = 1'b1;
          be_sel     = sel ? req_be1 : req_be0;
          cen        = 1'b1;
          gwen       = req_we[sel];
          a          = sel ? req_addr1 : req_addr0;
          if (req_we[sel]) begin
            d = sel ? req_wdata1 : req_wdata0;
            for (int k = 0; k < 4; k++) wen[8*k +: 8] = {8{be_sel[k]}};
          end
          rsp_valid_d = ~req_we[sel];
          rsp_id_d    = sel;
          state_d     = S_ACCESS;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      rr_q        <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_q        <= rr_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q && !rst;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Randomized self-checking bench for sram_arb_ctrl with a behavioural SRAM macro
// and a transaction-level reference model (word array, round-robin rule, response queue).
module tb_sram_arb_ctrl;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_we;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [31:0]   req_wdata0, req_wdata1;
  logic [3:0]    req_be0, req_be1;
  logic [1:0]    req_ready;
  logic          rsp_valid, rsp_id;
  logic [31:0]   rsp_rdata;
  logic          init_done;
  logic [AW-1:0] a;
  logic          cen, gwen;
  logic [31:0]   d, wen, q;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          rr_m;
  logic        exp_rv;
  logic        exp_id;
  logic [31:0] exp_data;

  // Behavioural single-port macro with registered read data
  logic [31:0] macro_mem [DEPTH];

  sram_arb_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_be0(req_be0), .req_be1(req_be1),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .a(a), .cen(cen), .d(d), .gwen(gwen), .wen(wen), .q(q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cen) begin
      if (gwen) macro_mem[a] <= (macro_mem[a] & ~wen) | (d & wen);
      else      q <= macro_mem[a];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    rr_m   = 0;
    exp_rv = 1'b0;
    exp_id = 1'b0;
  endtask

  // Called at a falling edge with rst currently high; releases reset and checks the zero-fill sweep.
  task automatic do_init();
    rst       = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("init_sweep",
            {init_done, req_ready, rsp_valid, cen, gwen, wen, d, a},
            {1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, AW'(i)});
      @(negedge clk);
    end
    check("init_done", init_done, 1'b1);
    model_reset();
  endtask

  // One clock cycle: drive at the falling edge, check combinational and registered outputs, advance.
  task automatic cyc(input logic [1:0] v, input logic [1:0] we,
                     input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [3:0] be0, input logic [3:0] be1);
    logic [1:0]    exp_g;
    int            w;
    logic [AW-1:0] ad;
    logic [31:0]   wd, mask;
    logic [3:0]    be;
    req_valid  = v;   req_we     = we;
    req_addr0  = ad0; req_addr1  = ad1;
    req_wdata0 = wd0; req_wdata1 = wd1;
    req_be0    = be0; req_be1    = be1;
    #1;
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      check("rsp_id", rsp_id, exp_id);
      check("rsp_rdata", rsp_rdata, exp_data);
    end
    exp_g = 2'b00;
    w     = -1;
    if (v == 2'b11) begin
      w    = rr_m;
      rr_m = 1 - rr_m;
    end else if (v[0]) w = 0;
    else if (v[1])     w = 1;
    if (w >= 0) exp_g[w] = 1'b1;
    check("req_ready", req_ready, exp_g);
    exp_rv = 1'b0;
    if (w < 0) begin
      check("idle_cen", cen, 1'b0);
    end else begin
      ad   = (w == 1) ? ad1 : ad0;
      wd   = (w == 1) ? wd1 : wd0;
      be   = (w == 1) ? be1 : be0;
      mask = 32'h0;
      for (int k = 0; k < 4; k++) if (be[k]) mask = mask | (32'hFF << (8 * k));
      if (we[w]) begin
        check("wr_macro", {cen, gwen, wen, d, a}, {1'b1, 1'b1, mask, wd, ad});
        ref_mem[ad] = (ref_mem[ad] & ~mask) | (wd & mask);
      end else begin
        check("rd_macro", {cen, gwen, wen, a}, {1'b1, 1'b0, 32'h0, ad});
        exp_rv   = 1'b1;
        exp_id   = (w == 1);
        exp_data = ref_mem[ad];
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0;
    req_be0 = '0; req_be1 = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state",
          {init_done, req_ready, rsp_valid, rsp_id, cen, gwen, wen, d, a}, '0);
    @(negedge clk);
    do_init();

    // Top word reads back as zero after the fill
    cyc(2'b01, 2'b00, 10'h3FF, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check("init_top_word", rsp_rdata, 32'h0);
    cyc(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);

    // Byte-masked writes then readback
    cyc(2'b01, 2'b01, 10'h005, 10'h0, 32'h1122_3344, 32'h0, 4'b1111, 4'h0);
    cyc(2'b01, 2'b01, 10'h005, 10'h0, 32'hAABB_CCDD, 32'h0, 4'b0101, 4'h0);
    cyc(2'b01, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check("byte_write_data", rsp_rdata, 32'h11BB_33DD);
    check("byte_write_id", rsp_id, 1'b0);

    // Zero byte-enable write consumes a slot but changes nothing
    cyc(2'b01, 2'b01, 10'h005, 10'h0, 32'hFFFF_FFFF, 32'h0, 4'b0000, 4'h0);
    cyc(2'b01, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check("be_zero_data", rsp_rdata, 32'h11BB_33DD);

    // Contention: alternate 0,1,0,1 with no empty cycle
    for (int i = 0; i < 4; i++)
      cyc(2'b11, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0, 4'h0, 4'h0);

    // Single requester keeps the pointer, next contended cycle goes to 0
    for (int i = 0; i < 5; i++)
      cyc(2'b10, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0, 4'h0, 4'h0);
    cyc(2'b11, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0, 4'h0, 4'h0);
    check("post_single_grant0", rsp_id, 1'b0);

    // Back-to-back write then read of the same word
    cyc(2'b10, 2'b10, 10'h0, 10'h100, 32'h0, 32'hDEAD_BEEF, 4'h0, 4'hF);
    cyc(2'b10, 2'b00, 10'h0, 10'h100, 32'h0, 32'h0, 4'h0, 4'h0);
    check("raw_data", rsp_rdata, 32'hDEAD_BEEF);
    check("raw_id", rsp_id, 1'b1);

    // Randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      logic [1:0] rv, rw;
      rv = 2'($urandom_range(0, 3));
      rw = 2'($urandom_range(0, 3));
      cyc(rv, rw,
          AW'(10'h200 + $urandom_range(0, 15)), AW'(10'h200 + $urandom_range(0, 15)),
          $urandom, $urandom,
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    cyc(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);

    // Mid-operation reset right after a read grant drops the response
    cyc(2'b01, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    rst       = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rst_rsp_dropped", rsp_valid, 1'b0);
    check("rst_no_grant", {req_ready, cen}, 3'b000);
    @(negedge clk);
    check("rst_state", {init_done, rsp_valid, cen, a}, '0);
    do_init();

    // Refilled array reads zero where data used to be
    cyc(2'b01, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    check("refill_data", rsp_rdata, 32'h0);
    cyc(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
